sobel_edge_detector: RTL and testbench
======================================

// Module: sobel_edge_detector
// PURPOSE
//  Consumes the 3x3 pixel window stream of the line-buffer stage and computes the Sobel gradient magnitude and a thresholded edge bit per window.
//  Fixed-latency 3-stage pipeline with no backpressure; sits directly downstream of the window generator.
//  Keeps a per-frame edge count that is published at frame end.
// PARAMETERS
//  IMAGE_WIDTH   128  pixels per line; must match the window generator
//  IMAGE_HEIGHT  128  lines per frame
// PORTS
//  clk           in   1   single clock, all logic on rising edge
//  reset_n       in   1   asynchronous, active-low reset
//  window_flat   in   72  3x3 window; p[k] = window_flat[8k+7:8k], k=0..8 row-major
//                         p0 = top-left (oldest line), p8 = bottom-right (newest pixel)
//  window_valid  in   1   window_flat is valid this cycle
//  threshold     in   8   edge threshold, unsigned
//  mag_out       out  8   saturated gradient magnitude
//  edge_out      out  1   1 when magnitude (pre-saturation) >= threshold
//  out_valid     out  1   mag_out/edge_out are valid this cycle
//  frame_done    out  1   one-cycle pulse coincident with the last output of a frame
//  edge_count    out  16  number of edge_out=1 results in the most recently completed frame
// BEHAVIOUR
//  Reset (async assert, sync release): mag_out=0, edge_out=0, out_valid=0, frame_done=0, edge_count=0; all pipeline valids and counters cleared.
//  Arithmetic (unsigned 8-bit in, signed 11-bit intermediates, no overflow possible):
//   Gx = (p2 + 2*p5 + p8) - (p0 + 2*p3 + p6)    range -1020..+1020
//   Gy = (p6 + 2*p7 + p8) - (p0 + 2*p1 + p2)    range -1020..+1020
//   M  = |Gx| + |Gy|, 11-bit unsigned, max 2040
//   mag_out = (M > 255) ? 255 : M[7:0];  edge_out = (M >= {3'b0,threshold})
//  Pipeline: S1 registers the four weighted column/row sums; S2 registers Gx, Gy and their absolute values; S3 registers M-derived outputs.
//   Latency is exactly 3 cycles: window_valid=1 at cycle N gives out_valid=1 at cycle N+3.
//   A valid bit travels with each stage; bubbles (window_valid=0) propagate as out_valid=0.
//   Data registers update only when their stage's valid is 1; when out_valid=0, mag_out and edge_out hold their last values.
//  threshold is sampled in S3 on the cycle the result is formed; a change takes effect for the next result leaving S3.
//  Frame accounting: WPF = (IMAGE_WIDTH-2)*(IMAGE_HEIGHT-2) valid windows per frame.
//   win_cnt counts out_valid cycles and edge_acc counts out_valid&&edge_out cycles.
//   When out_valid=1 and win_cnt==WPF-1: frame_done=1 that cycle, edge_count <= edge_acc + edge_out, and win_cnt and edge_acc return to 0.
//   Otherwise frame_done=0 and edge_count holds.
//   edge_acc saturates at 16'hFFFF; it does not wrap.
//  Boundaries:
//   back-to-back valids are sustained at 1 result/cycle;
//   an isolated single valid produces exactly one out_valid pulse;
//   M == threshold counts as an edge; threshold = 0 makes every valid result an edge;
//   reset_n asserted mid-frame flushes in-flight results (no out_valid afterwards from pre-reset data) and restarts frame counting from 0.
// TESTING
//  T1 flat window, all p=100, threshold=1, one valid -> 3 cycles later out_valid=1, mag_out=0, edge_out=0.
//  T2 left column 0, right column 255, middle 0, threshold=128 -> Gx=1020, Gy=0, M=1020, mag_out=255, edge_out=1.
//  T3 left column 10, right column 20 (M=40): threshold=40 -> edge_out=1, mag_out=40; threshold=41 -> edge_out=0.
//  T4 valid pattern 1,0,1,1,0,1 -> out_valid repeats the same pattern delayed by exactly 3 cycles, with results in matching order.
//  T5 IMAGE_WIDTH=IMAGE_HEIGHT=5 (WPF=9), 9 valid windows with 4 edges -> frame_done high only with the 9th out_valid, edge_count=4;
//     a 10th window starts a new count.
//  T6 reset_n pulsed low while 2 valids are in flight -> all outputs 0 immediately, no out_valid after release, edge_count=0.

Source files
------------

// File: rtl/sobel_edge_detector.sv
// Sobel gradient magnitude and edge flag over a streamed 3x3 window, 3-cycle fixed latency,
// with a per-frame edge count published when the frame's last result leaves the pipeline.
module sobel_edge_detector #(
    parameter int IMAGE_WIDTH  = 128,
    parameter int IMAGE_HEIGHT = 128
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [71:0] window_flat,
    input  logic        window_valid,
    input  logic [7:0]  threshold,
    output logic [7:0]  mag_out,
    output logic        edge_out,
    output logic        out_valid,
    output logic        frame_done,
    output logic [15:0] edge_count
);

    localparam int WPF   = (IMAGE_WIDTH - 2) * (IMAGE_HEIGHT - 2);
    localparam int CNT_W = (WPF > 1) ? $clog2(WPF) : 1;
    localparam logic [CNT_W-1:0] LAST_WIN = CNT_W'(WPF - 1);

    // Valid semantics: a stage's data is meaningful only while its valid bit is 1. There is
    // no ready; every window accepted is emitted exactly three cycles later.
    logic [7:0]  w_p [9];
    logic [9:0]  w_gx_pos, w_gx_neg, w_gy_pos, w_gy_neg;
    logic        r_s1_valid;
    logic [9:0]  r_gx_pos, r_gx_neg, r_gy_pos, r_gy_neg;

    always_comb begin
        for (int k = 0; k < 9; k++) begin
            w_p[k] = window_flat[8*k +: 8];
        end
    end

    assign w_gx_pos = 10'(w_p[2]) + (10'(w_p[5]) << 1) + 10'(w_p[8]);
    assign w_gx_neg = 10'(w_p[0]) + (10'(w_p[3]) << 1) + 10'(w_p[6]);
    assign w_gy_pos = 10'(w_p[6]) + (10'(w_p[7]) << 1) + 10'(w_p[8]);
    assign w_gy_neg = 10'(w_p[0]) + (10'(w_p[1]) << 1) + 10'(w_p[2]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_gx_pos   <= '0;
            r_gx_neg   <= '0;
            r_gy_pos   <= '0;
            r_gy_neg   <= '0;
        end else begin
            r_s1_valid <= window_valid;
            if (window_valid) begin
                r_gx_pos <= w_gx_pos;
                r_gx_neg <= w_gx_neg;
                r_gy_pos <= w_gy_pos;
                r_gy_neg <= w_gy_neg;
            end
        end
    end

    // Only the magnitudes of Gx/Gy feed S3, so the signed values are not kept past this stage.
    logic signed [10:0] w_gx, w_gy;
    logic [9:0]         w_abs_gx, w_abs_gy;
    logic               r_s2_valid;
    logic [9:0]         r_abs_gx, r_abs_gy;

    assign w_gx     = $signed({1'b0, r_gx_pos}) - $signed({1'b0, r_gx_neg});
    assign w_gy     = $signed({1'b0, r_gy_pos}) - $signed({1'b0, r_gy_neg});
    assign w_abs_gx = w_gx[10] ? 10'(-w_gx) : w_gx[9:0];
    assign w_abs_gy = w_gy[10] ? 10'(-w_gy) : w_gy[9:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_valid <= 1'b0;
            r_abs_gx   <= '0;
            r_abs_gy   <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_abs_gx <= w_abs_gx;
                r_abs_gy <= w_abs_gy;
            end
        end
    end

    logic [10:0] w_m;
    logic        r_out_valid;
    logic [7:0]  r_mag;
    logic        r_edge;

    assign w_m = 11'(r_abs_gx) + 11'(r_abs_gy);

    // The edge decision uses the unsaturated magnitude against the threshold present now.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_mag       <= '0;
            r_edge      <= 1'b0;
        end else begin
            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_mag  <= (w_m > 11'd255) ? 8'hFF : w_m[7:0];
                r_edge <= (w_m >= {3'b000, threshold});
            end
        end
    end

    logic [CNT_W-1:0] r_win_cnt;
    logic [15:0]      r_edge_acc;
    logic [15:0]      r_edge_count;
    logic [15:0]      w_acc_next;
    logic             w_last_win;

    assign w_last_win = r_out_valid && (r_win_cnt == LAST_WIN);
    assign w_acc_next = (r_edge && (r_edge_acc != 16'hFFFF)) ? r_edge_acc + 16'd1 : r_edge_acc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_win_cnt    <= '0;
            r_edge_acc   <= '0;
            r_edge_count <= '0;
        end else if (r_out_valid) begin
            if (w_last_win) begin
                r_win_cnt    <= '0;
                r_edge_acc   <= '0;
                r_edge_count <= w_acc_next;
            end else begin
                r_win_cnt  <= r_win_cnt + 1'b1;
                r_edge_acc <= w_acc_next;
            end
        end
    end

    assign mag_out    = r_mag;
    assign edge_out   = r_edge;
    assign out_valid  = r_out_valid;
    assign frame_done = w_last_win;
    assign edge_count = r_edge_count;

endmodule

// File: tb/tb_sobel_edge_detector.sv
// Directed bench for sobel_edge_detector on a 5x5 frame (9 windows per frame).
module tb_sobel_edge_detector;

    localparam int WPF = 9;

    logic        clk;
    logic        reset_n;
    logic [71:0] window_flat;
    logic        window_valid;
    logic [7:0]  threshold;
    logic [7:0]  mag_out;
    logic        edge_out;
    logic        out_valid;
    logic        frame_done;
    logic [15:0] edge_count;

    sobel_edge_detector #(
        .IMAGE_WIDTH (5),
        .IMAGE_HEIGHT(5)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .window_flat (window_flat),
        .window_valid(window_valid),
        .threshold   (threshold),
        .mag_out     (mag_out),
        .edge_out    (edge_out),
        .out_valid   (out_valid),
        .frame_done  (frame_done),
        .edge_count  (edge_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [8:0]  exp_q[$];
    logic [2:0]  vpipe = 3'b000;
    int          m_win = 0;
    logic [15:0] m_acc = 16'd0;
    logic [15:0] m_edge_count = 16'd0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Called at a falling edge: check what is visible now, then drive the next input cycle.
    task automatic step(input logic v, input logic [71:0] w, input logic [7:0] em, input logic ee);
        logic [8:0] e;
        logic       last;
        last = vpipe[2] && (m_win == WPF - 1);
        check("out_valid", 16'(out_valid), 16'(vpipe[2]));
        check("frame_done", 16'(frame_done), 16'(last));
        check("edge_count", edge_count, m_edge_count);
        if (vpipe[2]) begin
            if (exp_q.size() == 0) begin
                check("exp_q_underflow", 16'd1, 16'd0);
            end else begin
                e = exp_q.pop_front();
                check("mag_out", 16'(mag_out), 16'(e[8:1]));
                check("edge_out", 16'(edge_out), 16'(e[0]));
                if (last) begin
                    m_edge_count = m_acc + 16'(e[0]);
                    m_acc        = 16'd0;
                    m_win        = 0;
                end else begin
                    m_win++;
                    m_acc = m_acc + 16'(e[0]);
                end
            end
        end
        window_valid = v;
        window_flat  = w;
        if (v) exp_q.push_back({em, ee});
        vpipe = {vpipe[1:0], v};
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 72'd0, 8'd0, 1'b0);
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        check("rst_out_valid", 16'(out_valid), 16'd0);
        check("rst_mag_out", 16'(mag_out), 16'd0);
        check("rst_edge_out", 16'(edge_out), 16'd0);
        check("rst_frame_done", 16'(frame_done), 16'd0);
        check("rst_edge_count", edge_count, 16'd0);
        window_valid = 1'b0;
        window_flat  = 72'd0;
        exp_q.delete();
        vpipe        = 3'b000;
        m_win        = 0;
        m_acc        = 16'd0;
        m_edge_count = 16'd0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    function automatic logic [71:0] mk3(input logic [7:0] l, input logic [7:0] m, input logic [7:0] r);
        return {r, m, l, r, m, l, r, m, l};
    endfunction

    function automatic logic [71:0] p0_only(input logic [7:0] k);
        return {64'd0, k};
    endfunction

    logic [71:0] w_flat100, w_edge, w_flat0;

    initial begin
        reset_n      = 1'b0;
        window_valid = 1'b0;
        window_flat  = 72'd0;
        threshold    = 8'd0;
        w_flat100    = {9{8'd100}};
        w_edge       = mk3(8'd0, 8'd0, 8'd255);
        w_flat0      = 72'd0;
        @(negedge clk);
        do_reset();

        // T1: flat window -> zero gradient
        threshold = 8'd1;
        step(1'b1, w_flat100, 8'd0, 1'b0);
        idle(4);

        // T2: strong vertical edge, M=1020 saturates
        threshold = 8'd128;
        step(1'b1, w_edge, 8'd255, 1'b1);
        idle(4);

        // T3: M=40 exactly at and just below threshold
        threshold = 8'd40;
        step(1'b1, mk3(8'd10, 8'd15, 8'd20), 8'd40, 1'b1);
        idle(4);
        threshold = 8'd41;
        step(1'b1, mk3(8'd10, 8'd15, 8'd20), 8'd40, 1'b0);
        idle(4);

        // Negative Gy (M=800), small Gy (M=12), both gradients negative (M=100), back to back
        threshold = 8'd128;
        step(1'b1, {8'd0, 8'd0, 8'd0, 8'd50, 8'd50, 8'd50, 8'd200, 8'd200, 8'd200}, 8'd255, 1'b1);
        step(1'b1, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd3, 8'd3, 8'd3}, 8'd12, 1'b0);
        step(1'b1, p0_only(8'd50), 8'd100, 1'b0);
        idle(4);

        // Threshold 0: zero magnitude still counts as an edge
        threshold = 8'd0;
        step(1'b1, w_flat100, 8'd0, 1'b1);
        idle(4);

        // T4: valid pattern 1,0,1,1,0,1 with distinct results (M = 2*p0)
        threshold = 8'd13;
        step(1'b1, p0_only(8'd5), 8'd10, 1'b0);
        step(1'b0, 72'd0, 8'd0, 1'b0);
        step(1'b1, p0_only(8'd6), 8'd12, 1'b0);
        step(1'b1, p0_only(8'd7), 8'd14, 1'b1);
        step(1'b0, 72'd0, 8'd0, 1'b0);
        step(1'b1, p0_only(8'd8), 8'd16, 1'b1);
        idle(4);

        // T5: one full frame of 9 windows with 4 edges, then a 10th window
        do_reset();
        threshold = 8'd128;
        step(1'b1, w_edge, 8'd255, 1'b1);
        step(1'b1, w_flat0, 8'd0, 1'b0);
        step(1'b1, w_edge, 8'd255, 1'b1);
        step(1'b1, w_flat0, 8'd0, 1'b0);
        step(1'b1, w_flat0, 8'd0, 1'b0);
        step(1'b1, w_edge, 8'd255, 1'b1);
        step(1'b1, w_flat0, 8'd0, 1'b0);
        step(1'b1, w_edge, 8'd255, 1'b1);
        step(1'b1, w_flat0, 8'd0, 1'b0);
        step(1'b1, w_edge, 8'd255, 1'b1);
        idle(4);
        check("t5_edge_count", edge_count, 16'd4);

        // T6: reset while results are in flight
        step(1'b1, w_edge, 8'd255, 1'b1);
        step(1'b1, w_edge, 8'd255, 1'b1);
        step(1'b1, w_edge, 8'd255, 1'b1);
        check("t6_pre_out_valid", 16'(out_valid), 16'd1);
        do_reset();
        idle(5);
        check("t6_edge_count", edge_count, 16'd0);
        step(1'b1, w_edge, 8'd255, 1'b1);
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
